// File: rtl/seven_seg_scan.sv
// seven_seg_scan: 4-digit common-anode scan controller with shadow commit,
// blanking gap and leading-zero suppression; all outputs registered.
module seven_seg_scan #(
  parameter int PRESCALE = 50000,
  parameter int BLANK = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        lzb,
  input  logic        load,
  output logic [3:0]  nibble,
  output logic [3:0]  digit_en,
  output logic        dp,
  output logic        frame_done
);
  localparam int CW = $clog2(PRESCALE);
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   pend_val, act_val;
  logic [3:0]    pend_dp, act_dp;
  logic          pend_lzb, act_lzb, pend;
  logic          wrap, last, supp, dark;
  logic [3:0]    cur;
  // cnt/idx name the position the next edge presents, so edge 1 after reset shows digit 0, position 0
  always_comb begin
    wrap = cnt == CW'(PRESCALE - 1);
    last = wrap && idx == 2'd3;
    cur  = act_val[{idx, 2'b00} +: 4];
    supp = act_lzb && idx != 2'd0 && (act_val >> {idx, 2'b00}) == 16'd0;
    dark = cnt < CW'(BLANK) || supp;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      nibble     <= '0;
      digit_en   <= 4'hF;
      dp         <= 1'b0;
      frame_done <= 1'b0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_lzb   <= 1'b0;
      pend       <= 1'b0;
      act_val    <= '0;
      act_dp     <= '0;
      act_lzb    <= 1'b0;
    end else begin
      cnt        <= wrap ? '0 : cnt + CW'(1);
      idx        <= wrap ? idx + 2'd1 : idx;
      nibble     <= cur;
      digit_en   <= dark ? 4'hF : ~(4'b0001 << idx);
      dp         <= !dark && act_dp[idx];
      frame_done <= last;
      if (load) {pend_val, pend_dp, pend_lzb} <= {value, dp_in, lzb};
      pend <= last ? 1'b0 : pend || load;
      // the active set only moves on the frame boundary, so no frame mixes two values
      if (last && (load || pend))
        {act_val, act_dp, act_lzb} <= load ? {value, dp_in, lzb} : {pend_val, pend_dp, pend_lzb};
    end
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: randomized and directed checks of seven_seg_scan against
// an edge-numbered reference model (PRESCALE=4, BLANK=1).
module tb_seven_seg_scan;
  localparam int PS = 4;
  localparam int BL = 1;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        lzb = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  nibble, digit_en;
  logic        dp, frame_done;
  int          total = 0, bad = 0, n = 0;
  logic [15:0] a_val, p_val;
  logic [3:0]  a_dp, p_dp;
  logic        a_lzb, p_lzb, pf;
  logic [9:0]  exp_out;

  seven_seg_scan #(.PRESCALE(PS), .BLANK(BL)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .lzb(lzb),
    .load(load), .nibble(nibble), .digit_en(digit_en), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    n = 0; a_val = '0; a_dp = '0; a_lzb = 1'b0;
    p_val = '0; p_dp = '0; p_lzb = 1'b0; pf = 1'b0;
  endtask

  // Starts and ends at a falling edge; models the edge just taken from the spec's edge-numbering rules
  task automatic tick(input bit ld, input logic [15:0] v, input logic [3:0] d, input bit z);
    int p, dg;
    logic [3:0] nb, en;
    logic       sup, edp, fd;
    load = ld; value = v; dp_in = d; lzb = z;
    @(posedge clk);
    n++;
    p   = (n - 1) % PS;
    dg  = ((n - 1) / PS) % 4;
    nb  = 4'((a_val >> (4 * dg)) & 16'hF);
    sup = a_lzb && dg != 0 && (a_val >> (4 * dg)) == 0;
    en  = (p < BL || sup) ? 4'hF : 4'((~(1 << dg)) & 4'hF);
    edp = (p < BL || sup) ? 1'b0 : a_dp[dg];
    fd  = dg == 3 && p == PS - 1;
    exp_out = {nb, en, edp, fd};
    if (ld) begin p_val = v; p_dp = d; p_lzb = z; pf = 1'b1; end
    if (fd) begin
      if (ld) begin a_val = v; a_dp = d; a_lzb = z; end
      else if (pf) begin a_val = p_val; a_dp = p_dp; a_lzb = p_lzb; end
      pf = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; load = 1'b0;
    @(negedge clk);
    model_clear();
    rst_n = 1'b1;
  endtask

  task automatic idle();
    tick(1'b0, 16'($urandom), 4'($urandom), 1'($urandom));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b1; value = 16'hFFFF; dp_in = 4'hF; lzb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({nibble, digit_en, dp, frame_done} !== 10'b0000_1111_0_0) begin
        bad++; $display("FAIL reset_hold got=%b exp=%b", {nibble, digit_en, dp, frame_done}, 10'b0000_1111_0_0);
      end
    end
    model_clear();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      idle();
      total++;
      if ({nibble, digit_en, dp, frame_done} !== exp_out) begin
        bad++; $display("FAIL reset_scan n=%0d got=%b exp=%b", n, {nibble, digit_en, dp, frame_done}, exp_out);
      end
    end
  endtask

  task automatic test_basic();
    do_reset();
    for (int i = 0; i < 48; i++) begin
      if (i == 1) tick(1'b1, 16'h1234, 4'b0100, 1'b0);
      else idle();
      total++;
      if ({nibble, digit_en, dp, frame_done} !== exp_out) begin
        bad++; $display("FAIL basic n=%0d got=%b exp=%b", n, {nibble, digit_en, dp, frame_done}, exp_out);
      end
      if (n == 27) begin
        total++;
        if ({nibble, digit_en, dp} !== {4'h2, 4'b1011, 1'b1}) begin
          bad++; $display("FAIL basic_digit2 got=%b exp=%b", {nibble, digit_en, dp}, {4'h2, 4'b1011, 1'b1});
        end
      end
      if (n == 16 || n == 32) begin
        total++;
        if (frame_done !== 1'b1) begin
          bad++; $display("FAIL basic_frame_done n=%0d got=%b exp=1", n, frame_done);
        end
      end
    end
  endtask

  task automatic test_lzb();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      if (i == 0) tick(1'b1, 16'h0050, 4'b0000, 1'b1);
      else if (i == 20) tick(1'b1, 16'h0000, 4'b0001, 1'b1);
      else idle();
      total++;
      if ({nibble, digit_en, dp, frame_done} !== exp_out) begin
        bad++; $display("FAIL lzb n=%0d got=%b exp=%b", n, {nibble, digit_en, dp, frame_done}, exp_out);
      end
      if ((n > 24 && n <= 32) || (n > 36 && n <= 48)) begin
        total++;
        if (digit_en !== 4'hF) begin
          bad++; $display("FAIL lzb_dark n=%0d got=%b exp=1111", n, digit_en);
        end
      end
    end
  endtask

  task automatic test_tear();
    do_reset();
    for (int i = 0; i < 48; i++) begin
      if (i == 0) tick(1'b1, 16'hAAAA, 4'b0000, 1'b0);
      else if (i == 22) tick(1'b1, 16'hBBBB, 4'b0000, 1'b0);
      else if (i == 27) tick(1'b1, 16'hCCCC, 4'b0000, 1'b0);
      else idle();
      total++;
      if ({nibble, digit_en, dp, frame_done} !== exp_out) begin
        bad++; $display("FAIL tear n=%0d got=%b exp=%b", n, {nibble, digit_en, dp, frame_done}, exp_out);
      end
      if (n > 16) begin
        total++;
        if (nibble !== (n <= 32 ? 4'hA : 4'hC)) begin
          bad++; $display("FAIL tear_value n=%0d got=%h exp=%h", n, nibble, n <= 32 ? 4'hA : 4'hC);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    while (n % 16 != 15) idle();
    tick(1'b1, 16'h9876, 4'b0000, 1'b0);
    total++;
    if (frame_done !== 1'b1 || {nibble, digit_en, dp, frame_done} !== exp_out) begin
      bad++; $display("FAIL b2b_commit got=%b exp=%b", {nibble, digit_en, dp, frame_done}, exp_out);
    end
    tick(1'b1, 16'h5555, 4'b0000, 1'b0);
    total++;
    if ({nibble, digit_en} !== {4'h6, 4'hF} || {nibble, digit_en, dp, frame_done} !== exp_out) begin
      bad++; $display("FAIL b2b_next got=%b exp=%b", {nibble, digit_en, dp, frame_done}, {4'h6, 4'hF, 2'b00});
    end
    for (int i = 0; i < 15; i++) begin
      idle();
      total++;
      if (nibble === 4'h5 || {nibble, digit_en, dp, frame_done} !== exp_out) begin
        bad++; $display("FAIL b2b_wait i=%0d got=%b exp=%b", i, {nibble, digit_en, dp, frame_done}, exp_out);
      end
    end
    idle();
    total++;
    if (nibble !== 4'h5) begin
      bad++; $display("FAIL b2b_late got=%h exp=5", nibble);
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int i = 0; i < 400; i++) begin
      v = 16'($urandom);
      for (int k = 0; k < 4; k++) if ($urandom_range(1, 0) == 1) v[4 * k +: 4] = 4'h0;
      if ($urandom_range(4, 0) == 0) tick(1'b1, v, 4'($urandom), 1'($urandom));
      else idle();
      total++;
      if ({nibble, digit_en, dp, frame_done} !== exp_out) begin
        bad++; $display("FAIL random n=%0d got=%b exp=%b", n, {nibble, digit_en, dp, frame_done}, exp_out);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(1'b1, 16'h4321, 4'b0000, 1'b0);
    while (n < 26) begin
      idle();
      total++;
      if ({nibble, digit_en, dp, frame_done} !== exp_out) begin
        bad++; $display("FAIL midrst_run n=%0d got=%b exp=%b", n, {nibble, digit_en, dp, frame_done}, exp_out);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({nibble, digit_en, dp, frame_done} !== 10'b0000_1111_0_0) begin
      bad++; $display("FAIL midrst_async got=%b exp=%b", {nibble, digit_en, dp, frame_done}, 10'b0000_1111_0_0);
    end
    @(negedge clk);
    model_clear();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      idle();
      total++;
      if (nibble !== 4'h0 || {nibble, digit_en, dp, frame_done} !== exp_out) begin
        bad++; $display("FAIL midrst_after n=%0d got=%b exp=%b", n, {nibble, digit_en, dp, frame_done}, exp_out);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_lzb();
    test_tear();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
